comms_processor_core: RTL and testbench
=======================================

# comms_processor_core

Communication processor between a node's general-purpose processor (GPP) and the photonic interconnect. It packs GPP words into 32-bit data packets with a control-channel request/grant handshake. It also receives announced data bursts from remote nodes into a local buffer and hands them to the GPP on request. One instance sits on each node, between the GPP and the control/data waveguide interfaces.

## Interface
- No parameters. Buffer depth is fixed at 16 words. All 16-bit ids are treated as unsigned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `node_id` in 16: this node's id (static).
- `max_node` in 16: highest valid node id (static).
- `control_rx_packet` in 32: incoming control packet, {id[31:16], payload[15:0]}.
- `enable_rtr` in 1: global enable for GPP read-out of received data.
- `gpp_rtr_cp` in 1: GPP ready to receive (control level).
- `control_tx_packet` out 32: outgoing control packet.
- `data_rx_node_id` out 16: source id of the buffered received message.
- `data_rx_flag` out 1: a complete received message is buffered.
- `gpp_trf_cp` out 1: message waiting notification to the GPP.
- `data_rx_packet` in 32: incoming data packet, {src id, word}.
- `gpp_rtr_dp` in 1: GPP pops one received word per cycle.
- `RAM_rx_data_out` out 16: received word popped to the GPP.
- `gpp_trf_dp` in 1: GPP pushes `gpp_tx_data` while high.
- `gpp_tx_data` in 16: word to transmit.
- `data_tx_packet` out 32: outgoing data packet, {node_id, word}.

## Operation
- A packet is valid iff its id field is in the range 1..`max_node`. An all-zero packet means idle.
- **TX stack** is 16×16 LIFO.
  - States: T_IDLE, T_REQ, T_SEND.
  - T_IDLE: each cycle `gpp_trf_dp`=1 pushes `gpp_tx_data`. Pushes beyond 16 are dropped.
  - When `gpp_trf_dp` is 0 and count>0, go to T_REQ. By convention the GPP's last word is the word count; the block does not interpret it.
  - T_REQ: drive `control_tx_packet`={node_id, count}. Wait for a valid `control_rx_packet` with payload 0xFFFF (grant), then go to T_SEND.
  - T_SEND: each cycle output `data_tx_packet`={node_id, pop}, in LIFO order. After the last word, return to T_IDLE with both tx outputs at 0.
- **RX stack** is 16×16 LIFO.
  - States: R_IDLE, R_RECV, R_FULL, R_READ.
  - R_IDLE: a valid `control_rx_packet` with payload n in 1..16 latches src=id and n. It also drives grant `control_tx_packet`={node_id, 0xFFFF} for exactly one cycle, then goes to R_RECV. A payload of 0, 0xFFFF or >16 is ignored.
  - R_RECV: each cycle, if `data_rx_packet`[31:16]==src, push [15:0]. After n pushes, go to R_FULL.
  - R_FULL: `data_rx_flag`=1, `data_rx_node_id`=src, `gpp_trf_cp`=1. When `enable_rtr` && `gpp_rtr_cp`, go to R_READ and set `gpp_trf_cp`=0.
  - R_READ: each cycle with `gpp_rtr_dp`=1, pop to `RAM_rx_data_out`. After the last pop, go to R_IDLE and clear `data_rx_flag` and `data_rx_node_id`.
- LIFO on both ends restores the GPP's original word order at the receiver.
- `control_tx_packet` arbitration: the RX grant cycle has priority over the TX request. The request is held, so it reappears the next cycle.
- TX and RX operate concurrently and independently.

## Timing
- All outputs are registered. Reset value of every output is 0. Both stacks are empty and both FSMs idle.
- Reset mid-operation aborts any transfer and discards buffered words.
- TX request appears 1 cycle after `gpp_trf_dp` falls.
- First `data_tx_packet` appears 1 cycle after the grant is sampled. One word per cycle with no gaps.
- RX grant appears 1 cycle after the announcement is sampled.
- `data_rx_flag` rises 1 cycle after the n-th data word is sampled.
- `RAM_rx_data_out` is valid 1 cycle after `gpp_rtr_dp` is sampled. It holds its value when `gpp_rtr_dp`=0.
- Simultaneous push and full: the word is dropped. A pop on an empty stack is a no-op.

## Test plan
- **Reset:** assert `rst` mid-burst → all outputs 0 immediately; FSMs idle.
- **TX request:** node_id=1, max_node=4; push 0x000A, 0x000B, 0x000C, 0x000D, 0x0005 → `control_tx_packet`=0x00010005 held.
- **TX send:**
  - Grant: `control_rx_packet`=0x0001FFFF → `data_tx_packet` = 0x00010005, 0x0001000D, 0x0001000C, 0x0001000B, 0x0001000A on consecutive cycles, then 0.
  - No grant: with no grant the request holds indefinitely.
- **RX receive:**
  - Announce: `control_rx_packet`=0x00010005 → grant 0x0001FFFF for one cycle.
  - Data: data packets 0x00010005, 0x0001000D, 0x0001000C, 0x0001000B, 0x0001000A → `data_rx_flag`=1, `data_rx_node_id`=1, `gpp_trf_cp`=1.
- **RX read-out:**
  - `enable_rtr`=`gpp_rtr_cp`=1 → `gpp_trf_cp`=0.
  - `gpp_rtr_dp` held high → `RAM_rx_data_out` = 0x000A, 0x000B, 0x000C, 0x000D, 0x0005; then the flag clears.
- **Invalid packets:** announcement id 5 (> max_node), id 0, or payload 17 → ignored with no grant. A data word from a mismatched src is not stored.

Source files
------------

// File: rtl/comms_processor_core_if.sv
// comms_processor_core_if: GPP, control and data waveguide signals of one node.
// master = node environment (GPP + links), slave = comms_processor_core.
interface comms_processor_core_if;
  logic [15:0] node_id;
  logic [15:0] max_node;
  logic [31:0] control_rx_packet;
  logic        enable_rtr;
  logic        gpp_rtr_cp;
  logic [31:0] control_tx_packet;
  logic [15:0] data_rx_node_id;
  logic        data_rx_flag;
  logic        gpp_trf_cp;
  logic [31:0] data_rx_packet;
  logic        gpp_rtr_dp;
  logic [15:0] RAM_rx_data_out;
  logic        gpp_trf_dp;
  logic [15:0] gpp_tx_data;
  logic [31:0] data_tx_packet;

  modport master (
    output node_id, max_node, control_rx_packet,
    output enable_rtr, gpp_rtr_cp, data_rx_packet,
    output gpp_rtr_dp, gpp_trf_dp, gpp_tx_data,
    input  control_tx_packet, data_rx_node_id,
    input  data_rx_flag, gpp_trf_cp,
    input  RAM_rx_data_out, data_tx_packet
  );

  modport slave (
    input  node_id, max_node, control_rx_packet,
    input  enable_rtr, gpp_rtr_cp, data_rx_packet,
    input  gpp_rtr_dp, gpp_trf_dp, gpp_tx_data,
    output control_tx_packet, data_rx_node_id,
    output data_rx_flag, gpp_trf_cp,
    output RAM_rx_data_out, data_tx_packet
  );
endinterface

// File: rtl/comms_processor_core.sv
// comms_processor_core: packs GPP words into data packets (TX LIFO) and
// buffers announced remote bursts (RX LIFO). Ports: clk, rst, bus (slave).
module comms_processor_core (
  input  logic clk,
  input  logic rst,
  comms_processor_core_if.slave bus
);

  localparam logic [15:0] GRANT = 16'hFFFF;

  typedef enum logic [1:0] {
    T_IDLE, T_REQ, T_SEND
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_RECV, R_FULL, R_READ
  } rx_state_t;

  // control packet decode
  logic [15:0] ctrl_id;
  logic [15:0] ctrl_pl;
  logic        ctrl_ok;
  logic        grant_in;
  logic        announce;

  assign ctrl_id  = bus.control_rx_packet[31:16];
  assign ctrl_pl  = bus.control_rx_packet[15:0];
  assign ctrl_ok  = (ctrl_id != '0) &&
                    (ctrl_id <= bus.max_node);
  assign grant_in = ctrl_ok && (ctrl_pl == GRANT);
  assign announce = ctrl_ok && (ctrl_pl != '0) &&
                    (ctrl_pl <= 16'd16);

  // TX stack
  tx_state_t   tx_state;
  tx_state_t   tx_next;
  logic [4:0]  tx_cnt;
  logic [3:0]  tx_top;
  logic [15:0] tx_mem [16];
  logic        tx_push;
  logic        tx_pop;

  assign tx_top  = tx_cnt[3:0] - 4'd1;
  assign tx_push = (tx_state == T_IDLE) && bus.gpp_trf_dp &&
                   (tx_cnt < 5'd16);
  // popping follows the next state so the first word leaves on the
  // same edge that samples the grant
  assign tx_pop  = (tx_next == T_SEND) && (tx_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      T_IDLE:
        if (!bus.gpp_trf_dp && (tx_cnt != '0))
          tx_next = T_REQ;
      T_REQ:
        if (grant_in) tx_next = T_SEND;
      T_SEND:
        if (tx_cnt == '0) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tx_cnt <= '0;
    else if (tx_push) tx_cnt <= tx_cnt + 5'd1;
    else if (tx_pop)  tx_cnt <= tx_cnt - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_cnt[3:0]] <= bus.gpp_tx_data;
  end

  // RX stack
  rx_state_t   rx_state;
  rx_state_t   rx_next;
  logic [15:0] rx_src;
  logic [4:0]  rx_n;
  logic [4:0]  rx_cnt;
  logic [3:0]  rx_top;
  logic [15:0] rx_mem [16];
  logic        rx_grant;
  logic        rx_push;
  logic        rx_pop;

  assign rx_top   = rx_cnt[3:0] - 4'd1;
  assign rx_grant = (rx_state == R_IDLE) && announce;
  assign rx_push  = (rx_state == R_RECV) &&
                    (bus.data_rx_packet[31:16] == rx_src) &&
                    (rx_cnt < 5'd16);
  assign rx_pop   = (rx_state == R_READ) && bus.gpp_rtr_dp &&
                    (rx_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      R_IDLE:
        if (announce) rx_next = R_RECV;
      R_RECV:
        if (rx_push && (rx_cnt + 5'd1 == rx_n))
          rx_next = R_FULL;
      R_FULL:
        if (bus.enable_rtr && bus.gpp_rtr_cp)
          rx_next = R_READ;
      R_READ:
        if (rx_pop && (rx_cnt == 5'd1))
          rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_src <= '0;
      rx_n   <= '0;
    end else if (rx_grant) begin
      rx_src <= ctrl_id;
      rx_n   <= ctrl_pl[4:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rx_cnt <= '0;
    else if (rx_push) rx_cnt <= rx_cnt + 5'd1;
    else if (rx_pop)  rx_cnt <= rx_cnt - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_cnt[3:0]] <= bus.data_rx_packet[15:0];
  end

  // next values of the registered outputs
  logic [31:0] ctrl_tx_d;
  logic [31:0] data_tx_d;
  logic [15:0] src_d;
  logic [15:0] ram_d;
  logic        flag_d;
  logic        trf_cp_d;

  always_comb begin
    ctrl_tx_d = '0;
    // the one-cycle RX grant wins; a pending request simply
    // shows again on the following cycle
    if (rx_grant)
      ctrl_tx_d = {bus.node_id, GRANT};
    else if (tx_next == T_REQ)
      ctrl_tx_d = {bus.node_id, 11'd0, tx_cnt};
    data_tx_d = '0;
    if (tx_pop)
      data_tx_d = {bus.node_id, tx_mem[tx_top]};
    flag_d   = (rx_next == R_FULL) || (rx_next == R_READ);
    src_d    = flag_d ? rx_src : '0;
    trf_cp_d = (rx_next == R_FULL);
    ram_d    = bus.RAM_rx_data_out;
    if (rx_pop) ram_d = rx_mem[rx_top];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.control_tx_packet <= '0;
      bus.data_tx_packet    <= '0;
      bus.data_rx_node_id   <= '0;
      bus.data_rx_flag      <= 1'b0;
      bus.gpp_trf_cp        <= 1'b0;
      bus.RAM_rx_data_out   <= '0;
    end else begin
      bus.control_tx_packet <= ctrl_tx_d;
      bus.data_tx_packet    <= data_tx_d;
      bus.data_rx_node_id   <= src_d;
      bus.data_rx_flag      <= flag_d;
      bus.gpp_trf_cp        <= trf_cp_d;
      bus.RAM_rx_data_out   <= ram_d;
    end
  end

endmodule

// File: tb/tb_comms_processor_core.sv
// tb_comms_processor_core: random + directed bursts against a queue model.
// Drives on negedge, samples on the following negedge.
module tb_comms_processor_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  comms_processor_core_if bus();

  comms_processor_core dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] NID  = 16'd1;
  localparam logic [15:0] MAXN = 16'd4;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] txq [$];
  logic [15:0] rxq [$];
  logic [15:0] stim [$];
  logic [15:0] exp_ram;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, bus.control_tx_packet, 32'd0);
    chk({tag, "_data"}, bus.data_tx_packet, 32'd0);
    chk({tag, "_src"}, {16'd0, bus.data_rx_node_id}, 32'd0);
    chk({tag, "_flag"}, {31'd0, bus.data_rx_flag}, 32'd0);
    chk({tag, "_cp"}, {31'd0, bus.gpp_trf_cp}, 32'd0);
    chk({tag, "_ram"}, {16'd0, bus.RAM_rx_data_out}, 32'd0);
  endtask

  task automatic tx_burst(input int len);
    logic [15:0] w;
    logic [31:0] req;
    int h;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      w = (stim.size() > 0) ? stim.pop_front() : 16'($urandom);
      bus.gpp_trf_dp  = 1'b1;
      bus.gpp_tx_data = w;
      if (txq.size() < 16) txq.push_back(w);
    end
    @(negedge clk);
    bus.gpp_trf_dp  = 1'b0;
    bus.gpp_tx_data = '0;
    chk("tx_no_req_yet", bus.control_tx_packet, 32'd0);
    req = {NID, 16'(txq.size())};
    h = $urandom_range(1, 4);
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      chk("tx_req", bus.control_tx_packet, req);
      chk("tx_nodata", bus.data_tx_packet, 32'd0);
      // grants from out-of-range ids must not release the burst
      bus.control_rx_packet = (i % 2 == 0) ?
        {MAXN + 16'd1, 16'hFFFF} : {16'd0, 16'hFFFF};
    end
    @(negedge clk);
    chk("tx_req_hold", bus.control_tx_packet, req);
    bus.control_rx_packet = {16'($urandom_range(1, 4)), 16'hFFFF};
    while (txq.size() > 0) begin
      @(negedge clk);
      bus.control_rx_packet = '0;
      chk("tx_data", bus.data_tx_packet, {NID, txq.pop_back()});
      chk("tx_ctrl_off", bus.control_tx_packet, 32'd0);
    end
    @(negedge clk);
    chk("tx_end", bus.data_tx_packet, 32'd0);
  endtask

  task automatic rx_burst(input int n, input logic [15:0] src,
                          input bit spec);
    logic [15:0] w;
    logic [15:0] other;
    int got;
    int k;
    bit dp;
    other = (src == MAXN) ? 16'd1 : src + 16'd1;
    @(negedge clk);
    bus.control_rx_packet = {src, 16'(n)};
    @(negedge clk);
    bus.control_rx_packet = '0;
    chk("rx_grant", bus.control_tx_packet, {NID, 16'hFFFF});
    @(negedge clk);
    chk("rx_grant_1cyc", bus.control_tx_packet, 32'd0);
    got = 0;
    while (got < n) begin
      k = spec ? 3 : $urandom_range(0, 3);
      if (k == 0) begin
        bus.data_rx_packet = {other, 16'($urandom)};
      end else if (k == 1) begin
        bus.data_rx_packet = '0;
      end else begin
        w = (stim.size() > 0) ? stim.pop_front() : 16'($urandom);
        bus.data_rx_packet = {src, w};
        rxq.push_back(w);
        got++;
      end
      @(negedge clk);
      bus.data_rx_packet = '0;
      chk("rx_flag", {31'd0, bus.data_rx_flag}, 32'(got == n));
    end
    chk("rx_src", {16'd0, bus.data_rx_node_id}, {16'd0, src});
    chk("rx_trf_cp", {31'd0, bus.gpp_trf_cp}, 32'd1);
    if ($urandom_range(0, 1) == 1) begin
      bus.enable_rtr = 1'b1;
      bus.gpp_rtr_cp = 1'b0;
    end else begin
      bus.enable_rtr = 1'b0;
      bus.gpp_rtr_cp = 1'b1;
    end
    @(negedge clk);
    chk("rx_cp_gated", {31'd0, bus.gpp_trf_cp}, 32'd1);
    bus.enable_rtr = 1'b1;
    bus.gpp_rtr_cp = 1'b1;
    @(negedge clk);
    bus.enable_rtr = 1'b0;
    bus.gpp_rtr_cp = 1'b0;
    chk("rx_cp_clr", {31'd0, bus.gpp_trf_cp}, 32'd0);
    chk("rx_flag_hold", {31'd0, bus.data_rx_flag}, 32'd1);
    while (rxq.size() > 0) begin
      dp = spec ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.gpp_rtr_dp = dp;
      @(negedge clk);
      if (dp) exp_ram = rxq.pop_back();
      chk("rx_data", {16'd0, bus.RAM_rx_data_out}, {16'd0, exp_ram});
      chk("rx_flag_rd", {31'd0, bus.data_rx_flag},
          32'(rxq.size() != 0));
    end
    bus.gpp_rtr_dp = 1'b0;
    chk("rx_src_clr", {16'd0, bus.data_rx_node_id}, 32'd0);
  endtask

  logic [31:0] bad [5];

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.node_id           = NID;
    bus.max_node          = MAXN;
    bus.control_rx_packet = '0;
    bus.enable_rtr        = 1'b0;
    bus.gpp_rtr_cp        = 1'b0;
    bus.data_rx_packet    = '0;
    bus.gpp_rtr_dp        = 1'b0;
    bus.gpp_trf_dp        = 1'b0;
    bus.gpp_tx_data       = '0;
    exp_ram = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    stim = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h0005};
    tx_burst(5);

    stim = '{16'h0005, 16'h000D, 16'h000C, 16'h000B, 16'h000A};
    rx_burst(5, 16'd1, 1'b1);

    bad = '{32'h00050005, 32'h00000005, 32'h00010011,
            32'h00010000, 32'h0001FFFF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.control_rx_packet = bad[i];
      @(negedge clk);
      bus.control_rx_packet = '0;
      chk("bad_ann", bus.control_tx_packet, 32'd0);
      @(negedge clk);
      chk("bad_ann_flag", {31'd0, bus.data_rx_flag}, 32'd0);
    end

    rx_burst($urandom_range(1, 16), 16'($urandom_range(1, 4)), 1'b0);
    tx_burst(18);
    rx_burst(16, 16'd4, 1'b0);
    rx_burst(1, 16'd2, 1'b0);
    tx_burst(1);

    // TX request pre-empted by an RX grant, then reset mid-burst
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.gpp_trf_dp  = 1'b1;
      bus.gpp_tx_data = 16'($urandom);
    end
    @(negedge clk);
    bus.gpp_trf_dp = 1'b0;
    @(negedge clk);
    chk("arb_req", bus.control_tx_packet, {NID, 16'd3});
    bus.control_rx_packet = {16'd2, 16'd4};
    @(negedge clk);
    bus.control_rx_packet = '0;
    chk("arb_grant", bus.control_tx_packet, {NID, 16'hFFFF});
    @(negedge clk);
    chk("arb_req_back", bus.control_tx_packet, {NID, 16'd3});
    bus.data_rx_packet = {16'd2, 16'h1234};
    @(negedge clk);
    bus.data_rx_packet = {16'd2, 16'h5678};
    @(negedge clk);
    bus.data_rx_packet = '0;
    #1 rst = 1'b1;
    #1 chk_zero("mid_rst");
    exp_ram = '0;
    txq.delete();
    rxq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", bus.control_tx_packet, 32'd0);
    rx_burst(3, 16'd3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1)
        tx_burst($urandom_range(1, 18));
      else
        rx_burst($urandom_range(1, 16),
                 16'($urandom_range(1, 4)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
